// File: rtl/de_pipe_stage.sv
// Decode-to-execute pipeline stage: valid/ready payload register with optional
// 2-entry skid buffer, flush-to-bubble and a saturating stall-cycle counter.
module de_pipe_stage #(
  parameter int unsigned      WIDTH  = 128,
  parameter bit               SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] main_q, main_n;
  logic [WIDTH-1:0] skid_q, skid_n;
  logic             rdy_q;
  logic             accept;
  logic             pop;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  // Skid mode registers in_ready so out_ready never reaches it combinationally.
  assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = EMPTY;
      main_n  = BUBBLE;
      skid_n  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            main_n  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_n = in_data;
          end else if (accept) begin
            state_n = TWO;
            skid_n  = in_data;
          end else if (pop) begin
            state_n = EMPTY;
            main_n  = BUBBLE;
          end
        end
        TWO: begin
          if (pop) begin
            state_n = ONE;
            main_n  = skid_q;
            skid_n  = BUBBLE;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n  = BUBBLE;
          skid_n  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
      rdy_q   <= (state_n != TWO);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
